// File: rtl/demux_rr.sv
// Round-robin byte demultiplexer feeding two 4-deep FIFOs. Bytes alternate
// between channels, skip a full channel, and are dropped when both are full.
module demux_rr #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop_0,
    input  logic              pop_1,
    output logic [DATA_W-1:0] data_out_0,
    output logic              valid_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic              valid_out_1,
    output logic              full_0,
    output logic              full_1,
    output logic              drop_out
);

    logic [DATA_W-1:0] mem_q    [2][4];
    logic [DATA_W-1:0] mem_d    [2][4];
    logic [1:0]        wr_ptr_q [2];
    logic [1:0]        wr_ptr_d [2];
    logic [1:0]        rd_ptr_q [2];
    logic [1:0]        rd_ptr_d [2];
    logic [2:0]        cnt_q    [2];
    logic [2:0]        cnt_d    [2];
    logic              sel_q;
    logic              sel_d;
    logic              drop_q;
    logic              drop_d;

    logic [1:0]        has_room;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic              alt;

    always_comb begin
        alt         = ~sel_q;
        has_room[0] = (cnt_q[0] != 3'd4);
        has_room[1] = (cnt_q[1] != 3'd4);
        pop[0]      = pop_0 && (cnt_q[0] != 3'd0);
        pop[1]      = pop_1 && (cnt_q[1] != 3'd0);

        // Room is judged on the pre-edge count, so a same-cycle pop never frees a slot.
        push = 2'b00;
        if (valid_in) begin
            if (has_room[sel_q]) begin
                push[sel_q] = 1'b1;
            end else if (has_room[alt]) begin
                push[alt] = 1'b1;
            end
        end

        for (int c = 0; c < 2; c++) begin
            mem_d[c]    = mem_q[c];
            wr_ptr_d[c] = wr_ptr_q[c] + 2'(push[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + 2'(pop[c]);
            cnt_d[c]    = cnt_q[c] + 3'(push[c]) - 3'(pop[c]);
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = data_in;
            end
        end

        if (push[0]) begin
            sel_d = 1'b1;
        end else if (push[1]) begin
            sel_d = 1'b0;
        end else begin
            sel_d = sel_q;
        end

        drop_d = valid_in && (push == 2'b00);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int c = 0; c < 2; c++) begin
                for (int e = 0; e < 4; e++) begin
                    mem_q[c][e] <= '0;
                end
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            sel_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                mem_q[c]    <= mem_d[c];
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            sel_q  <= sel_d;
            drop_q <= drop_d;
        end
    end

    assign data_out_0  = mem_q[0][rd_ptr_q[0]];
    assign data_out_1  = mem_q[1][rd_ptr_q[1]];
    assign valid_out_0 = (cnt_q[0] != 3'd0);
    assign valid_out_1 = (cnt_q[1] != 3'd0);
    assign full_0      = (cnt_q[0] == 3'd4);
    assign full_1      = (cnt_q[1] == 3'd4);
    assign drop_out    = drop_q;

endmodule

// File: tb/tb_demux_rr.sv
// Bench for demux_rr: directed vector table, corner-case sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_demux_rr;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       valid_in;
    logic [7:0] data_in;
    logic       pop_0, pop_1;
    logic [7:0] data_out_0, data_out_1;
    logic       valid_out_0, valid_out_1, full_0, full_1, drop_out;

    demux_rr dut (
        .clk(clk), .reset_L(reset_L), .valid_in(valid_in), .data_in(data_in),
        .pop_0(pop_0), .pop_1(pop_1),
        .data_out_0(data_out_0), .valid_out_0(valid_out_0),
        .data_out_1(data_out_1), .valid_out_1(valid_out_1),
        .full_0(full_0), .full_1(full_1), .drop_out(drop_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: one queue per channel, preferred-channel bit, drop flag.
    logic [7:0] mq0[$];
    logic [7:0] mq1[$];
    logic       m_sel;
    logic       m_drop;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       p0, p1;
        logic       ev0, ev1, ef0, ef1, edrop;
        logic [7:0] ed0, ed1;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mq0.delete();
        mq1.delete();
        m_sel  = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic p0, input logic p1);
        int n0 = mq0.size();
        int n1 = mq1.size();
        int tgt = -1;
        if (v) begin
            if (m_sel == 1'b0) tgt = (n0 < 4) ? 0 : ((n1 < 4) ? 1 : -1);
            else               tgt = (n1 < 4) ? 1 : ((n0 < 4) ? 0 : -1);
        end
        if (p0 && n0 > 0) void'(mq0.pop_front());
        if (p1 && n1 > 0) void'(mq1.pop_front());
        if (tgt == 0) begin mq0.push_back(d); m_sel = 1'b1; end
        if (tgt == 1) begin mq1.push_back(d); m_sel = 1'b0; end
        m_drop = v && (tgt < 0);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid0"}, 8'(valid_out_0), 8'(mq0.size() != 0));
        chk({tag, "_valid1"}, 8'(valid_out_1), 8'(mq1.size() != 0));
        chk({tag, "_full0"},  8'(full_0),      8'(mq0.size() == 4));
        chk({tag, "_full1"},  8'(full_1),      8'(mq1.size() == 4));
        chk({tag, "_drop"},   8'(drop_out),    8'(m_drop));
        if (mq0.size() != 0) chk({tag, "_data0"}, data_out_0, mq0[0]);
        if (mq1.size() != 0) chk({tag, "_data1"}, data_out_1, mq1[0]);
    endtask

    // Called at posedge+1; drives inputs, advances one edge, checks at posedge+1.
    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic p0, input logic p1);
        valid_in = v;
        data_in  = d;
        pop_0    = p0;
        pop_1    = p1;
        @(posedge clk);
        model_step(v, d, p0, p1);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        pop_0    = 1'b0;
        pop_1    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        check_model("reset");
        chk("reset_data0", data_out_0, 8'h00);
        chk("reset_data1", data_out_1, 8'h00);
        reset_L = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0, 8'h00};
        tbl[1] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, 8'hA1};
        tbl[2] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, 8'hA1};
        tbl[3] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, 8'hA1};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA2, 8'hA3};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

        do_reset();

        // Alternation table
        for (int i = 0; i < 6; i++) begin
            step($sformatf("alt%0d", i), tbl[i].v, tbl[i].d, tbl[i].p0, tbl[i].p1);
            chk($sformatf("tbl%0d_v0", i), 8'(valid_out_0), 8'(tbl[i].ev0));
            chk($sformatf("tbl%0d_v1", i), 8'(valid_out_1), 8'(tbl[i].ev1));
            chk($sformatf("tbl%0d_f0", i), 8'(full_0), 8'(tbl[i].ef0));
            chk($sformatf("tbl%0d_f1", i), 8'(full_1), 8'(tbl[i].ef1));
            chk($sformatf("tbl%0d_drop", i), 8'(drop_out), 8'(tbl[i].edrop));
            if (tbl[i].ev0) chk($sformatf("tbl%0d_d0", i), data_out_0, tbl[i].ed0);
            if (tbl[i].ev1) chk($sformatf("tbl%0d_d1", i), data_out_1, tbl[i].ed1);
        end

        // Skip full: q0 gets 4, q1 gets 4, one pop on q1, then 0x55 with sel=0
        for (int i = 0; i < 8; i++) step("fill", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step("pop1", 1'b0, 8'h00, 1'b0, 1'b1);
        step("skip", 1'b1, 8'h55, 1'b0, 1'b0);
        chk("skip_full0", 8'(full_0), 8'h01);
        chk("skip_full1", 8'(full_1), 8'h01);
        chk("skip_drop", 8'(drop_out), 8'h00);

        // Overflow: both full
        step("ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf_drop", 8'(drop_out), 8'h01);
        step("ovf_idle", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_drop_clear", 8'(drop_out), 8'h00);
        chk("ovf_full0", 8'(full_0), 8'h01);
        chk("ovf_full1", 8'(full_1), 8'h01);

        // Full push+pop: pop does not make room for the same-cycle push
        step("fpp", 1'b1, 8'h77, 1'b1, 1'b0);
        chk("fpp_drop", 8'(drop_out), 8'h01);
        chk("fpp_full0", 8'(full_0), 8'h00);
        chk("fpp_valid0", 8'(valid_out_0), 8'h01);

        // Observe that sel held at 0, then drain everything in order
        step("pp", 1'b0, 8'h00, 1'b1, 1'b1);
        step("sel_hold", 1'b1, 8'h88, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b1);

        // Empty pop, then push/pop pairs across pointer wrap
        do_reset();
        step("empty_pop", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("empty_pop_v1", 8'(valid_out_1), 8'h00);
        for (int i = 0; i < 12; i++) step("wrap", 1'b1, 8'(8'hC0 + i), 1'b1, 1'b1);
        step("wrap_end", 1'b0, 8'h00, 1'b1, 1'b1);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        #3;
        reset_L = 1'b0;
        #1;
        chk("arst_v0", 8'(valid_out_0), 8'h00);
        chk("arst_v1", 8'(valid_out_1), 8'h00);
        chk("arst_f0", 8'(full_0), 8'h00);
        chk("arst_f1", 8'(full_1), 8'h00);
        chk("arst_drop", 8'(drop_out), 8'h00);
        chk("arst_d0", data_out_0, 8'h00);
        chk("arst_d1", data_out_1, 8'h00);
        valid_in = 1'b1;
        data_in  = 8'h5A;
        pop_0    = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("arst_hold_v0", 8'(valid_out_0), 8'h00);
            chk("arst_hold_v1", 8'(valid_out_1), 8'h00);
        end
        reset_L = 1'b1;
        model_clear();
        step("post_rst", 1'b1, 8'h99, 1'b0, 1'b0);
        chk("post_rst_v0", 8'(valid_out_0), 8'h01);
        chk("post_rst_d0", data_out_0, 8'h99);
        chk("post_rst_v1", 8'(valid_out_1), 8'h00);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'(($urandom % 4) != 0), 8'($urandom),
                 1'(($urandom % 5) < 2), 1'(($urandom % 5) < 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_rr.md
DEMUX_RR -- requirements
Module: demux_rr

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset_L  input  1  asynchronous active-low reset.
REQ-004 valid_in  input  1  qualifies data_in this cycle.
REQ-005 data_in  input  8  incoming byte stream.
REQ-006 pop_0  input  1  consumer 0 takes the head of queue 0 this cycle.
REQ-007 pop_1  input  1  consumer 1 takes the head of queue 1 this cycle.
REQ-008 data_out_0  output  8  head entry of queue 0.
REQ-009 valid_out_0  output  1  queue 0 non-empty.
REQ-010 data_out_1  output  8  head entry of queue 1.
REQ-011 valid_out_1  output  1  queue 1 non-empty.
REQ-012 full_0  output  1  queue 0 holds 4 entries.
REQ-013 full_1  output  1  queue 1 holds 4 entries.
REQ-014 drop_out  output  1  one-cycle pulse flagging a discarded input byte.

Function
REQ-015 Each channel SHALL own a 4-entry x 8-bit FIFO with a 2-bit write pointer, a 2-bit read pointer and a 3-bit count (range 0..4), all wrapping modulo 4 on the pointers.
REQ-016 A 1-bit round-robin register sel SHALL name the preferred target channel.
REQ-017 On a cycle with valid_in=1, the target SHALL be sel if count[sel]<4 before this edge; otherwise ~sel if count[~sel]<4; otherwise none.
REQ-018 Fullness for acceptance SHALL use the pre-edge count; a pop on a full queue in the same cycle SHALL NOT make room for that cycle's push.
REQ-019 On acceptance into channel c, data_in SHALL be written at wr_ptr[c], wr_ptr[c] SHALL increment, and sel SHALL become ~c at the same edge.
REQ-020 When no target exists, the byte SHALL be discarded, sel SHALL hold, and drop_out SHALL be 1 for exactly the following cycle.
REQ-021 When valid_in=0, no write SHALL occur, sel SHALL hold, and drop_out SHALL be 0 the following cycle.
REQ-022 pop_c with count[c]>0 SHALL increment rd_ptr[c]; pop_c with count[c]=0 SHALL be ignored with no state change.
REQ-023 Simultaneous accepted push and valid pop on the same channel SHALL leave count unchanged and advance both pointers.
REQ-024 valid_out_c SHALL equal (count[c]!=0), full_c SHALL equal (count[c]==4), and data_out_c SHALL equal mem_c[rd_ptr[c]]; all SHALL be driven from registers only, with no combinational path from any input.
REQ-025 Latency SHALL be one cycle: a byte accepted at edge N into an empty queue SHALL appear on data_out_c with valid_out_c=1 immediately after edge N.
REQ-026 Byte order within each channel SHALL be preserved; every byte SHALL go to exactly one channel or be dropped.

Reset
REQ-027 Asserting reset_L=0 SHALL, without waiting for clk, clear all counts, pointers, FIFO entries, sel and drop_out to 0, forcing valid_out_0, valid_out_1, full_0, full_1 and drop_out to 0 and data_out_0 and data_out_1 to 8'h00.
REQ-028 Reset asserted mid-operation SHALL discard all queued bytes; the first accepted byte after deassertion SHALL go to channel 0.
REQ-029 Inputs SHALL be ignored while reset_L=0; normal operation SHALL resume on the first rising edge after deassertion.

Verification
REQ-030 Alternation: push 8'hA0, A1, A2, A3 on consecutive cycles with no pops -> queue 0 holds A0,A2; queue 1 holds A1,A3; drop_out stays 0.
REQ-031 Skip full: fill queue 0 to 4 entries, holding queue 1 at fewer than 4, then push 8'h55 with sel=0 -> 8'h55 enters queue 1, sel becomes 0, full_0=1.
REQ-032 Overflow: both queues full, push 8'hEE -> drop_out=1 for exactly one cycle, counts stay 4/4, sel unchanged.
REQ-033 Full push+pop: queue 0 full, queue 1 full, pop_0=1 with a push of 8'h77 on the same cycle -> 8'h77 dropped, count0 becomes 3.
REQ-034 Empty pop and wrap: pop_1 on an empty queue -> no change; then 6 push/pop pairs on queue 1 -> bytes emerge in order across pointer wrap.
REQ-035 Async reset: assert reset_L mid-stream between clock edges -> all outputs 0 immediately; after release, next push lands in queue 0.
